// File: rtl/rf_wr_arbiter.sv
// rf_wr_arbiter: the ALU and load writeback paths share one register-file write port; each has a FIFO; also flags RAW hazards for decode.
// Latency: a request accepted at the end of cycle t gives wr_en high in cycle t+2; throughput is one write per cycle.
// Backpressure: x_ready = !x_full from registered occupancy (low while reset is high); RF_WR_RR_EN selects round-robin, else MEM has fixed priority.

// Per-requester FIFO of {rd, data}. Every slot's rd and its valid bit are exposed so the hazard check can see all pending writes.
module rf_wr_fifo #(
  parameter int DW    = 32,
  parameter int RB    = 5,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [RB-1:0]            i_push_rd,
  input  logic [DW-1:0]            i_push_dat,
  input  logic                     i_pop,
  output logic [RB-1:0]            o_head_rd,
  output logic [DW-1:0]            o_head_dat,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [DEPTH-1:0]         o_ent_vld,
  output logic [DEPTH-1:0][RB-1:0] o_ent_rd
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][RB-1:0] r_rd;
  logic [DW-1:0]            r_dat [DEPTH];
  logic [DEPTH-1:0]         r_vld;
  logic [PW-1:0]            r_wptr;
  logic [PW-1:0]            r_rptr;
  logic [CW-1:0]            r_cnt;
  logic                     w_push;
  logic                     w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty    = (r_cnt == '0);
  assign o_full     = (r_cnt == CW'(DEPTH));
  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_head_rd  = r_rd[r_rptr];
  assign o_head_dat = r_dat[r_rptr];
  assign o_ent_vld  = r_vld;
  assign o_ent_rd   = r_rd;

  // Pointers, occupancy and slot-valid bits. Push and pop never touch the same slot in one cycle (that would need full or empty).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_vld  <= '0;
    end else begin
      if (w_push) begin
        r_wptr        <= ptr_inc(r_wptr);
        r_vld[r_wptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rptr        <= ptr_inc(r_rptr);
        r_vld[r_rptr] <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Entry payload storage. It needs no reset because r_vld qualifies every slot.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd[r_wptr]  <= i_push_rd;
      r_dat[r_wptr] <= i_push_dat;
    end
  end
endmodule

module rf_wr_arbiter #(
  parameter int WD_SIZE        = 32,
  parameter int INSTR_REG_BITS = 5,
  parameter int BUF_DEPTH      = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [INSTR_REG_BITS-1:0] alu_rd,
  input  logic [WD_SIZE-1:0]        alu_data,
  output logic                      alu_ready,
  input  logic                      mem_valid,
  input  logic [INSTR_REG_BITS-1:0] mem_rd,
  input  logic [WD_SIZE-1:0]        mem_data,
  output logic                      mem_ready,
  output logic                      wr_en,
  output logic [INSTR_REG_BITS-1:0] wr_rd,
  output logic [WD_SIZE-1:0]        wr_data,
  input  logic [INSTR_REG_BITS-1:0] dec_rs1,
  input  logic [INSTR_REG_BITS-1:0] dec_rs2,
  input  logic                      dec_rs1_used,
  input  logic                      dec_rs2_used,
  output logic                      hazard,
  output logic                      idle
);
  localparam int RB = INSTR_REG_BITS;

  logic                      w_alu_full, w_alu_empty, w_mem_full, w_mem_empty;
  logic [RB-1:0]             w_alu_head_rd, w_mem_head_rd;
  logic [WD_SIZE-1:0]        w_alu_head_dat, w_mem_head_dat;
  logic [BUF_DEPTH-1:0]      w_alu_ent_vld, w_mem_ent_vld;
  logic [BUF_DEPTH-1:0][RB-1:0] w_alu_ent_rd, w_mem_ent_rd;
  logic                      w_grant_alu, w_grant_mem, w_mem_prio;
  logic                      w_rs1_hit, w_rs2_hit;
  logic                      r_wr_en;
  logic [RB-1:0]             r_wr_rd;
  logic [WD_SIZE-1:0]        r_wr_data;

  // Ready is held low during reset so nothing is accepted on a reset edge.
  assign alu_ready = !w_alu_full && !reset;
  assign mem_ready = !w_mem_full && !reset;

  rf_wr_fifo #(.DW(WD_SIZE), .RB(RB), .DEPTH(BUF_DEPTH)) u_alu_fifo (
    .clk(clk), .reset(reset),
    .i_push(alu_valid && alu_ready), .i_push_rd(alu_rd), .i_push_dat(alu_data),
    .i_pop(w_grant_alu),
    .o_head_rd(w_alu_head_rd), .o_head_dat(w_alu_head_dat),
    .o_empty(w_alu_empty), .o_full(w_alu_full),
    .o_ent_vld(w_alu_ent_vld), .o_ent_rd(w_alu_ent_rd)
  );

  rf_wr_fifo #(.DW(WD_SIZE), .RB(RB), .DEPTH(BUF_DEPTH)) u_mem_fifo (
    .clk(clk), .reset(reset),
    .i_push(mem_valid && mem_ready), .i_push_rd(mem_rd), .i_push_dat(mem_data),
    .i_pop(w_grant_mem),
    .o_head_rd(w_mem_head_rd), .o_head_dat(w_mem_head_dat),
    .o_empty(w_mem_empty), .o_full(w_mem_full),
    .o_ent_vld(w_mem_ent_vld), .o_ent_rd(w_mem_ent_rd)
  );

`ifdef RF_WR_RR_EN
  logic r_rr_mem;

  assign w_mem_prio = r_rr_mem;

  // Round-robin pointer: flips whenever the requester it favours is granted, contended or not.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_mem <= 1'b1;
    end else if ((r_rr_mem && w_grant_mem) || (!r_rr_mem && w_grant_alu)) begin
      r_rr_mem <= !r_rr_mem;
    end
  end
`else
  assign w_mem_prio = 1'b1;
`endif

  assign w_grant_mem = !w_mem_empty && (w_alu_empty || w_mem_prio);
  assign w_grant_alu = !w_alu_empty && !w_grant_mem;

  // Output register: load the granted head. An rd=0 write is consumed without raising wr_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_rd   <= '0;
      r_wr_data <= '0;
    end else if (w_grant_mem) begin
      r_wr_en   <= (w_mem_head_rd != '0);
      r_wr_rd   <= w_mem_head_rd;
      r_wr_data <= w_mem_head_dat;
    end else if (w_grant_alu) begin
      r_wr_en   <= (w_alu_head_rd != '0);
      r_wr_rd   <= w_alu_head_rd;
      r_wr_data <= w_alu_head_dat;
    end else begin
      r_wr_en   <= 1'b0;
    end
  end

  assign wr_en   = r_wr_en;
  assign wr_rd   = r_wr_rd;
  assign wr_data = r_wr_data;

  // RAW hazard: a used, nonzero source matches any buffered rd or the write now on the port.
  always_comb begin
    w_rs1_hit = 1'b0;
    w_rs2_hit = 1'b0;
    for (int i = 0; i < BUF_DEPTH; i++) begin
      if (w_alu_ent_vld[i] && (w_alu_ent_rd[i] == dec_rs1)) w_rs1_hit = 1'b1;
      if (w_mem_ent_vld[i] && (w_mem_ent_rd[i] == dec_rs1)) w_rs1_hit = 1'b1;
      if (w_alu_ent_vld[i] && (w_alu_ent_rd[i] == dec_rs2)) w_rs2_hit = 1'b1;
      if (w_mem_ent_vld[i] && (w_mem_ent_rd[i] == dec_rs2)) w_rs2_hit = 1'b1;
    end
    if (r_wr_en && (r_wr_rd == dec_rs1)) w_rs1_hit = 1'b1;
    if (r_wr_en && (r_wr_rd == dec_rs2)) w_rs2_hit = 1'b1;
  end

  assign hazard = (dec_rs1_used && (dec_rs1 != '0) && w_rs1_hit) ||
                  (dec_rs2_used && (dec_rs2 != '0) && w_rs2_hit);
  assign idle   = w_alu_empty && w_mem_empty && !r_wr_en;
endmodule

// File: tb/tb_rf_wr_arbiter.sv
module tb_rf_wr_arbiter;
  localparam int WD = 32;
  localparam int RB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, mem_valid;
  logic [RB-1:0] alu_rd, mem_rd;
  logic [WD-1:0] alu_data, mem_data;
  logic          alu_ready, mem_ready;
  logic          wr_en;
  logic [RB-1:0] wr_rd;
  logic [WD-1:0] wr_data;
  logic [RB-1:0] dec_rs1, dec_rs2;
  logic          dec_rs1_used, dec_rs2_used;
  logic          hazard, idle;

  typedef struct packed {
    logic [RB-1:0] rd;
    logic [WD-1:0] dat;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_on = 1'b0;
  int  ai;
  bit  ar;

  int  hz_rs1 [3] = '{9, 9, 3};
  bit  hz_u1  [3] = '{1'b1, 1'b0, 1'b1};
  int  hz_rs2 [3] = '{0, 0, 9};
  bit  hz_u2  [3] = '{1'b0, 1'b1, 1'b1};
  bit  hz_on  [3] = '{1'b1, 1'b0, 1'b1};

  always #5 clk = ~clk;

  rf_wr_arbiter #(.WD_SIZE(WD), .INSTR_REG_BITS(RB), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .hazard(hazard), .idle(idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input int rd, input logic [31:0] dat);
    wr_t e;
    e.rd  = RB'(rd);
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  // Start of next cycle: inputs change 1 time unit after the rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sampling point.
  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every wr_en pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (mon_on && wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_en", 32'(wr_en), 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("sb_wr_rd", 32'(wr_rd), 32'(e.rd));
        chk("sb_wr_data", wr_data, e.dat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;
    repeat (2) next();
    mid();
    chk("rst_alu_ready", 32'(alu_ready), 0);
    chk("rst_mem_ready", 32'(mem_ready), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_rd", 32'(wr_rd), 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_idle", 32'(idle), 1);
    next();
    reset = 1'b0;
    mon_on = 1'b1;
    mid();
    chk("rel_alu_ready", 32'(alu_ready), 1);
    chk("rel_mem_ready", 32'(mem_ready), 1);

    // Single ALU write rd=5: wr_en only in cycle t+2, idle low in t+1..t+2.
    next();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
    push_exp(5, 32'h0000_00AA);
    mid();
    chk("single_idle_t", 32'(idle), 1);
    next();
    alu_valid = 1'b0;
    mid();
    chk("single_wr_en_t1", 32'(wr_en), 0);
    chk("single_idle_t1", 32'(idle), 0);
    next();
    mid();
    chk("single_wr_en_t2", 32'(wr_en), 1);
    chk("single_idle_t2", 32'(idle), 0);
    next();
    mid();
    chk("single_wr_en_t3", 32'(wr_en), 0);
    chk("single_idle_t3", 32'(idle), 1);

    // rd=0 write: accepted, consumed silently.
    next();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    mid();
    chk("rd0_alu_ready", 32'(alu_ready), 1);
    next();
    alu_valid = 1'b0;
    mid();
    chk("rd0_idle_t1", 32'(idle), 0);
    next();
    mid();
    chk("rd0_wr_en_t2", 32'(wr_en), 0);
    chk("rd0_idle_t2", 32'(idle), 1);

    // Simultaneous ALU rd=3 / MEM rd=4 under fixed priority: 4 then 3.
    next();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    mem_valid = 1'b1; mem_rd = 5'd4; mem_data = 32'h44;
    push_exp(4, 32'h44);
    push_exp(3, 32'h33);
    next();
    alu_valid = 1'b0; mem_valid = 1'b0;
    next();
    mid();
    chk("pair_first_rd", 32'(wr_rd), 4);
    next();
    mid();
    chk("pair_second_en", 32'(wr_en), 1);
    chk("pair_second_rd", 32'(wr_rd), 3);
    next();
    mid();
    chk("pair_idle", 32'(idle), 1);

    // MEM flood against ALU traffic: MEM wins every contended cycle, ALU fills after 2.
    for (int c = 0; c < 6; c++) push_exp(10 + c, 32'h100 + 32'(c));
    for (int i = 0; i < 3; i++) push_exp(20 + i, 32'h200 + 32'(i));
    next();
    ai = 0;
    for (int c = 0; c < 6; c++) begin
      mem_valid = 1'b1; mem_rd = RB'(10 + c); mem_data = 32'h100 + 32'(c);
      alu_valid = (ai < 3); alu_rd = RB'(20 + ai); alu_data = 32'h200 + 32'(ai);
      mid();
      chk("flood_mem_ready", 32'(mem_ready), 1);
      if (c >= 2) chk("flood_alu_full", 32'(alu_ready), 0);
      ar = alu_ready;
      next();
      if (ar && alu_valid) ai++;
    end
    mem_valid = 1'b0;
    for (int c = 0; c < 20 && ai < 3; c++) begin
      alu_valid = 1'b1; alu_rd = RB'(20 + ai); alu_data = 32'h200 + 32'(ai);
      mid();
      ar = alu_ready;
      next();
      if (ar) ai++;
    end
    alu_valid = 1'b0;
    chk("flood_alu_accepted", 32'(ai), 3);
    repeat (5) next();
    mid();
    chk("flood_alu_ready_back", 32'(alu_ready), 1);
    chk("flood_drained", 32'(exp_q.size()), 0);
    chk("flood_idle", 32'(idle), 1);

    // Hazard against a pending MEM write to rd=9.
    for (int r = 0; r < 3; r++) begin
      next();
      mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h99;
      push_exp(9, 32'h99);
      dec_rs1 = RB'(hz_rs1[r]); dec_rs1_used = hz_u1[r];
      dec_rs2 = RB'(hz_rs2[r]); dec_rs2_used = hz_u2[r];
      for (int k = 0; k < 4; k++) begin
        mid();
        chk($sformatf("hazard_r%0d_c%0d", r, k), 32'(hazard),
            32'((k == 1 || k == 2) ? hz_on[r] : 1'b0));
        next();
        mem_valid = 1'b0;
      end
    end
    dec_rs1_used = 1'b0; dec_rs2_used = 1'b0;

    // Reset with ALU writes buffered behind a stream of silent rd=0 MEM writes.
    next();
    ai = 0;
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h5A5A;
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_rd = RB'(1 + ai); alu_data = 32'h300 + 32'(ai);
      mid();
      ar = alu_ready;
      next();
      if (ar) ai++;
    end
    reset = 1'b1;
    dec_rs1 = 5'd1; dec_rs1_used = 1'b1;
    mid();
    chk("mid_rst_hazard_before", 32'(hazard), 1);
    chk("mid_rst_alu_ready", 32'(alu_ready), 0);
    next();
    reset = 1'b0;
    alu_valid = 1'b0; mem_valid = 1'b0;
    mid();
    chk("mid_rst_idle", 32'(idle), 1);
    chk("mid_rst_alu_ready_rel", 32'(alu_ready), 1);
    chk("mid_rst_mem_ready_rel", 32'(mem_ready), 1);
    chk("mid_rst_hazard_after", 32'(hazard), 0);
    for (int c = 0; c < 4; c++) begin
      next();
      mid();
      chk("mid_rst_no_wr", 32'(wr_en), 0);
    end
    chk("final_queue_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
